regfile_write_scheduler: RTL and testbench
==========================================

Name: regfile_write_scheduler

Overview:
- Sequences the single write port of the 16-entry, 32-bit register file.
- Two write sources share the port: the in-order writeback stage (WB) and the multi-cycle multiply/divide unit (MDU).
- A one-entry hold buffer covers the case where WB and MDU collide.
- A busy-bit scoreboard stalls issue until outstanding long-latency results are committed.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register index width.
- NUM_REGS, 16, number of implemented registers; indices >= NUM_REGS are unimplemented.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- wb_valid  in  1  WB result present this cycle; cannot be back-pressured.
- wb_rd  in  ADDR_W  WB destination.
- wb_data  in  DATA_W  WB result.
- mdu_valid  in  1  MDU result offered.
- mdu_ready  out  1  scheduler accepts the MDU result; transfer = mdu_valid & mdu_ready.
- mdu_rd  in  ADDR_W  MDU destination.
- mdu_data  in  DATA_W  MDU result.
- issue_valid  in  1  decode stage presents an instruction.
- issue_long  in  1  instruction is an MDU (long-latency) op.
- issue_rs, issue_rt, issue_rd  in  ADDR_W  instruction register fields.
- stall  out  1  hold decode; combinational.
- rf_we  out  1  register file write enable; registered.
- rf_rd  out  ADDR_W  register file write index; registered.
- rf_wdata  out  DATA_W  register file write data; registered.
- busy  out  NUM_REGS  scoreboard bits, for debug and verification.

Behaviour:
- Reset values: rf_we=0, rf_rd=0, rf_wdata=0, busy=0, hold buffer empty, state=IDLE. Reset mid-operation discards any held MDU result and all busy bits.
- Write latency: the source is selected in cycle N; rf_we/rf_rd/rf_wdata are driven in cycle N+1. The register file commits on the negedge of N+1.
- A "droppable" index is 0 or >= NUM_REGS. A selected write to a droppable index produces rf_we=0 and still completes its handshake.
- States:
  - IDLE: mdu_ready=1.
    - wb_valid only: WB selected.
    - mdu transfer only: MDU selected.
    - Both: WB selected; MDU rd/data captured into the hold buffer; next state HELD.
    - Neither: rf_we=0 next cycle.
  - HELD: mdu_ready=0.
    - wb_valid=1: WB selected; remain HELD.
    - wb_valid=0: held entry selected; next state IDLE.
- Scoreboard set: on issue_valid & issue_long & !stall, set busy[issue_rd] unless issue_rd is droppable.
- Scoreboard clear: clear busy[rd] at the posedge that registers an MDU-sourced write into rf_*, whether direct or from the hold buffer. Clear applies even when rf_we=0 for a droppable index.
- Scoreboard conflict: set and clear of the same index at the same edge means set wins.
- Stall: stall = issue_valid & (busy[issue_rs] | busy[issue_rt] | busy[issue_rd]). This covers RAW and WAW. Indices >= NUM_REGS read as not busy.
- No bypass:
  - A busy bit cleared at the end of cycle N releases stall in N+1.
  - In N+1 the register file is written at the negedge, so the combinational read settles to the new value before the posedge ending N+1.
- WB writes never touch busy bits. WB targeting a busy register is allowed; it cannot occur for correct code because of the WAW stall.
- An MDU result for a non-busy rd is still written; this is not an error.

Decomposition:
- Shared package holds:
  - constants REG_COUNT=16, REG_IDX_W=5, DATA_W=32;
  - the state enum {IDLE, HELD};
  - the helper constant ZERO_REG=0.
- One sub-module is natural: regfile_scoreboard.
  - Contains the busy vector, set/clear logic and the stall compare.
  - Instantiated once.
  - The arbiter and hold buffer stay in the top module.

Test Plan:
- Reset: hold rst=1 with wb_valid=1, wb_rd=4 -> rf_we=0, busy=0, mdu_ready=1 throughout; first write appears the cycle after rst falls.
- WB only: wb_valid=1, wb_rd=5, wb_data=0x964EB in cycle N -> rf_we=1, rf_rd=5, rf_wdata=0x964EB in N+1; rf_we=0 in N+2.
- Collision:
  - Cycle N: WB (rd=2, 0x6) and MDU (rd=7, 0x964DA) both valid -> N+1 writes r2.
  - Cycle N+1: mdu_ready=0; wb_valid=1 (rd=8) -> N+2 writes r8.
  - Cycle N+2: wb_valid=0 -> N+3 writes r7=0x964DA; mdu_ready=1 again in N+3.
- Scoreboard:
  - Issue long op, rd=10 -> busy[10]=1 next cycle.
  - Issue rs=10 -> stall=1.
  - MDU returns rd=10, 0x1230B -> busy[10]=0 and stall=0 in the cycle rf_we=1, rf_rd=10.
- Zero and out-of-range targets:
  - MDU result to rd=0, and WB to rd=20 -> handshakes complete, rf_we stays 0.
  - Long issue with rd=0 -> no busy bit set.
- Same-edge set/clear:
  - MDU write of r11 registers on the same edge a new long op issues rd=11 -> busy[11] remains 1.
  - A later issue with rs=11 stalls.

Source files
------------

// File: rtl/regfile_write_scheduler_pkg.sv
// regfile_write_scheduler_pkg: shared constants and arbiter state type for the register file write scheduler
package regfile_write_scheduler_pkg;
  localparam int unsigned REG_COUNT = 16;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ZERO_REG = 0;
  typedef enum logic [0:0] {IDLE, HELD} state_t;
endpackage

// File: rtl/regfile_write_scheduler_scoreboard.sv
// regfile_write_scheduler_scoreboard: busy bits for outstanding long-latency destinations and the issue stall compare
module regfile_write_scheduler_scoreboard #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_long,
  input  logic [ADDR_W-1:0]   issue_rs,
  input  logic [ADDR_W-1:0]   issue_rt,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_rd,
  output logic [NUM_REGS-1:0] busy,
  output logic                stall
);
  import regfile_write_scheduler_pkg::*;
  localparam int unsigned EXT_W = 2 ** ADDR_W;
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_next;
  logic [EXT_W-1:0]    w_busy_ext;
  logic                w_set;
  // unimplemented indices read as zero through the widened vector
  assign w_busy_ext = EXT_W'(r_busy);
  assign stall = issue_valid & (w_busy_ext[issue_rs] | w_busy_ext[issue_rt] | w_busy_ext[issue_rd]);
  assign w_set = issue_valid & issue_long & ~stall & (32'(issue_rd) != ZERO_REG) & (32'(issue_rd) < NUM_REGS);
  assign busy = r_busy;
  always_comb begin
    w_next = '0;
    for (int i = 0; i < int'(NUM_REGS); i++)
      w_next[i] = (w_set && issue_rd == ADDR_W'(i)) || (r_busy[i] && !(clr_en && clr_rd == ADDR_W'(i)));
  end
  always_ff @(posedge clk)
    r_busy <= rst ? '0 : w_next;
endmodule

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: arbitrates WB and MDU onto the single register file write port with a one-entry MDU hold buffer
module regfile_write_scheduler #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                mdu_valid,
  output logic                mdu_ready,
  input  logic [ADDR_W-1:0]   mdu_rd,
  input  logic [DATA_W-1:0]   mdu_data,
  input  logic                issue_valid,
  input  logic                issue_long,
  input  logic [ADDR_W-1:0]   issue_rs,
  input  logic [ADDR_W-1:0]   issue_rt,
  input  logic [ADDR_W-1:0]   issue_rd,
  output logic                stall,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_rd,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [NUM_REGS-1:0] busy
);
  import regfile_write_scheduler_pkg::*;
  state_t              r_state;
  logic [ADDR_W-1:0]   r_hold_rd;
  logic [DATA_W-1:0]   r_hold_data;
  logic                r_we;
  logic [ADDR_W-1:0]   r_rd;
  logic [DATA_W-1:0]   r_wdata;
  logic                w_xfer;
  logic                w_sel_held;
  logic                w_sel_mdu;
  logic                w_sel_any;
  logic                w_drop;
  logic [ADDR_W-1:0]   w_sel_rd;
  logic [DATA_W-1:0]   w_sel_data;
  assign mdu_ready = r_state == IDLE;
  assign w_xfer = mdu_valid & mdu_ready;
  assign w_sel_held = r_state == HELD && !wb_valid;
  assign w_sel_mdu = w_xfer & ~wb_valid;
  assign w_sel_any = wb_valid | w_sel_held | w_sel_mdu;
  assign w_sel_rd = wb_valid ? wb_rd : w_sel_held ? r_hold_rd : mdu_rd;
  assign w_sel_data = wb_valid ? wb_data : w_sel_held ? r_hold_data : mdu_data;
  assign w_drop = 32'(w_sel_rd) == ZERO_REG || 32'(w_sel_rd) >= NUM_REGS;
  assign rf_we = r_we;
  assign rf_rd = r_rd;
  assign rf_wdata = r_wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_hold_rd <= '0;
      r_hold_data <= '0;
      r_we <= 1'b0;
      r_rd <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_sel_any & ~w_drop;
      if (w_sel_any) begin
        r_rd <= w_sel_rd;
        r_wdata <= w_sel_data;
      end
      // WB wins a collision; the accepted MDU result parks until WB goes quiet
      if (w_xfer && wb_valid) begin
        r_state <= HELD;
        r_hold_rd <= mdu_rd;
        r_hold_data <= mdu_data;
      end else if (w_sel_held) begin
        r_state <= IDLE;
      end
    end
  end
  regfile_write_scheduler_scoreboard #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_sb (
    .clk(clk),
    .rst(rst),
    .issue_valid(issue_valid),
    .issue_long(issue_long),
    .issue_rs(issue_rs),
    .issue_rt(issue_rt),
    .issue_rd(issue_rd),
    .clr_en(w_sel_mdu | w_sel_held),
    .clr_rd(w_sel_held ? r_hold_rd : mdu_rd),
    .busy(busy),
    .stall(stall)
  );
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb_regfile_write_scheduler: directed scenario tasks with hand-computed expectations
module tb_regfile_write_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, mdu_valid, mdu_ready, issue_valid, issue_long, stall, rf_we;
  logic [4:0]  wb_rd, mdu_rd, issue_rs, issue_rt, issue_rd, rf_rd;
  logic [31:0] wb_data, mdu_data, rf_wdata;
  logic [15:0] busy;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_write_scheduler dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .issue_valid(issue_valid), .issue_long(issue_long),
    .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rd(issue_rd),
    .stall(stall), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .busy(busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    issue_valid = 0; issue_long = 0; issue_rs = 0; issue_rt = 0; issue_rd = 0;
  endtask

  task automatic test_reset;
    quiet();
    rst = 1; wb_valid = 1; wb_rd = 4; wb_data = 32'h44;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_we got %b want 0", rf_we); end
      n_cmp++; if (busy !== 16'h0) begin n_err++; $display("FAIL reset_busy got %h want 0000", busy); end
      n_cmp++; if (mdu_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", mdu_ready); end
    end
    rst = 0;
    step();
    n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'd4 || rf_wdata !== 32'h44) begin n_err++; $display("FAIL reset_first_write got we=%b rd=%0d data=%h want 1/4/44", rf_we, rf_rd, rf_wdata); end
    quiet();
    step();
  endtask

  task automatic test_wb_only;
    wb_valid = 1; wb_rd = 5; wb_data = 32'h964EB;
    step();
    n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'h964EB) begin n_err++; $display("FAIL wb_only got we=%b rd=%0d data=%h want 1/5/964eb", rf_we, rf_rd, rf_wdata); end
    quiet();
    step();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL wb_only_idle got we=%b want 0", rf_we); end
  endtask

  task automatic test_collision;
    wb_valid = 1; wb_rd = 2; wb_data = 32'h6;
    mdu_valid = 1; mdu_rd = 7; mdu_data = 32'h964DA;
    #1;
    n_cmp++; if (mdu_ready !== 1'b1) begin n_err++; $display("FAIL coll_ready0 got %b want 1", mdu_ready); end
    step();
    n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'd2 || rf_wdata !== 32'h6) begin n_err++; $display("FAIL coll_wb got we=%b rd=%0d data=%h want 1/2/6", rf_we, rf_rd, rf_wdata); end
    n_cmp++; if (mdu_ready !== 1'b0) begin n_err++; $display("FAIL coll_ready1 got %b want 0", mdu_ready); end
    mdu_valid = 0; wb_rd = 8; wb_data = 32'h88;
    step();
    n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'd8 || rf_wdata !== 32'h88) begin n_err++; $display("FAIL coll_wb2 got we=%b rd=%0d data=%h want 1/8/88", rf_we, rf_rd, rf_wdata); end
    n_cmp++; if (mdu_ready !== 1'b0) begin n_err++; $display("FAIL coll_ready2 got %b want 0", mdu_ready); end
    quiet();
    step();
    n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h964DA) begin n_err++; $display("FAIL coll_held got we=%b rd=%0d data=%h want 1/7/964da", rf_we, rf_rd, rf_wdata); end
    n_cmp++; if (mdu_ready !== 1'b1) begin n_err++; $display("FAIL coll_ready3 got %b want 1", mdu_ready); end
    step();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL coll_idle got we=%b want 0", rf_we); end
  endtask

  task automatic test_scoreboard;
    issue_valid = 1; issue_long = 1; issue_rd = 10; issue_rs = 1; issue_rt = 2;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL sb_issue_stall got %b want 0", stall); end
    step();
    n_cmp++; if (busy !== 16'h0400) begin n_err++; $display("FAIL sb_set got %h want 0400", busy); end
    issue_long = 0; issue_rs = 10; issue_rt = 0; issue_rd = 3;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL sb_raw_rs got %b want 1", stall); end
    issue_rs = 0; issue_rt = 10;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL sb_raw_rt got %b want 1", stall); end
    mdu_valid = 1; mdu_rd = 10; mdu_data = 32'h1230B;
    step();
    n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'd10 || rf_wdata !== 32'h1230B) begin n_err++; $display("FAIL sb_mdu_write got we=%b rd=%0d data=%h want 1/10/1230b", rf_we, rf_rd, rf_wdata); end
    n_cmp++; if (busy !== 16'h0 || stall !== 1'b0) begin n_err++; $display("FAIL sb_clear got busy=%h stall=%b want 0000/0", busy, stall); end
    quiet();
    step();
  endtask

  task automatic test_held_clear;
    issue_valid = 1; issue_long = 1; issue_rd = 12;
    step();
    n_cmp++; if (busy !== 16'h1000) begin n_err++; $display("FAIL hc_set got %h want 1000", busy); end
    quiet();
    wb_valid = 1; wb_rd = 2; wb_data = 32'h1;
    mdu_valid = 1; mdu_rd = 12; mdu_data = 32'hC;
    step();
    n_cmp++; if (busy !== 16'h1000) begin n_err++; $display("FAIL hc_while_held got %h want 1000", busy); end
    quiet();
    step();
    n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'd12 || rf_wdata !== 32'hC || busy !== 16'h0) begin n_err++; $display("FAIL hc_commit got we=%b rd=%0d data=%h busy=%h want 1/12/c/0000", rf_we, rf_rd, rf_wdata, busy); end
  endtask

  task automatic test_drop;
    quiet();
    mdu_valid = 1; mdu_rd = 0; mdu_data = 32'h5;
    #1;
    n_cmp++; if (mdu_ready !== 1'b1) begin n_err++; $display("FAIL drop_r0_ready got %b want 1", mdu_ready); end
    step();
    n_cmp++; if (rf_we !== 1'b0 || mdu_ready !== 1'b1) begin n_err++; $display("FAIL drop_r0 got we=%b ready=%b want 0/1", rf_we, mdu_ready); end
    quiet();
    wb_valid = 1; wb_rd = 20; wb_data = 32'h20;
    step();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL drop_wb20 got we=%b want 0", rf_we); end
    quiet();
    issue_valid = 1; issue_long = 1; issue_rd = 0;
    step();
    n_cmp++; if (busy !== 16'h0) begin n_err++; $display("FAIL drop_issue_r0 got %h want 0000", busy); end
    issue_rd = 20;
    step();
    n_cmp++; if (busy !== 16'h0) begin n_err++; $display("FAIL drop_issue_r20 got %h want 0000", busy); end
    issue_long = 0; issue_rs = 20; issue_rt = 20; issue_rd = 20;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL drop_stall20 got %b want 0", stall); end
    quiet();
    step();
  endtask

  task automatic test_same_edge;
    mdu_valid = 1; mdu_rd = 11; mdu_data = 32'hB;
    issue_valid = 1; issue_long = 1; issue_rd = 11;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL se_stall0 got %b want 0", stall); end
    step();
    n_cmp++; if (busy !== 16'h0800 || rf_we !== 1'b1 || rf_rd !== 5'd11) begin n_err++; $display("FAIL se_set_wins got busy=%h we=%b rd=%0d want 0800/1/11", busy, rf_we, rf_rd); end
    quiet();
    issue_valid = 1; issue_rs = 11; issue_rd = 1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL se_stall1 got %b want 1", stall); end
    issue_valid = 0;
    mdu_valid = 1; mdu_rd = 11; mdu_data = 32'hBB;
    step();
    n_cmp++; if (busy !== 16'h0) begin n_err++; $display("FAIL se_clear got %h want 0000", busy); end
    quiet();
    step();
  endtask

  task automatic test_reset_mid;
    issue_valid = 1; issue_long = 1; issue_rd = 9;
    step();
    quiet();
    wb_valid = 1; wb_rd = 3; wb_data = 32'h3;
    mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h99;
    step();
    n_cmp++; if (mdu_ready !== 1'b0 || busy !== 16'h0200) begin n_err++; $display("FAIL rm_pre got ready=%b busy=%h want 0/0200", mdu_ready, busy); end
    quiet();
    rst = 1;
    step();
    n_cmp++; if (busy !== 16'h0 || rf_we !== 1'b0 || mdu_ready !== 1'b1) begin n_err++; $display("FAIL rm_reset got busy=%h we=%b ready=%b want 0000/0/1", busy, rf_we, mdu_ready); end
    rst = 0;
    step();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rm_discard got we=%b want 0", rf_we); end
  endtask

  initial begin
    test_reset();
    test_wb_only();
    test_collision();
    test_scoreboard();
    test_held_clear();
    test_drop();
    test_same_edge();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
